// File: rtl/poweron_sequencer_if.sv
// Rail-sequencer control/status bundle: start, delays and power-good in,
// rail enables and status out.
interface poweron_sequencer_if #(
   parameter int CH_NUM = 4,
   parameter int DLY_W  = 20
);
   localparam int FCH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic                    i_Start;
   logic [CH_NUM*DLY_W-1:0] i_Delay_cfg;
   logic [CH_NUM-1:0]       i_Pg;
   logic [CH_NUM-1:0]       o_En;
   logic                    o_All_done;
   logic                    o_Busy;
   logic                    o_Fault;
   logic [FCH_W-1:0]        o_Fault_ch;

   modport slave (
      input  i_Start,
      input  i_Delay_cfg,
      input  i_Pg,
      output o_En,
      output o_All_done,
      output o_Busy,
      output o_Fault,
      output o_Fault_ch
   );

   modport master (
      output i_Start,
      output i_Delay_cfg,
      output i_Pg,
      input  o_En,
      input  o_All_done,
      input  o_Busy,
      input  o_Fault,
      input  o_Fault_ch
   );
endinterface

// File: rtl/poweron_sequencer.sv
// Multi-rail power sequencer: ascending power-up with per-rail delay and PG
// wait, descending power-down, sticky fault shutdown on PG loss/timeout.
module poweron_sequencer #(
   parameter int SYSCLK_FREQ   = 125,
   parameter int CH_NUM        = 4,
   parameter int DLY_W         = 20,
   parameter int PG_TIMEOUT_US = 10000,
   parameter int DOWN_DELAY_US = 100
) (
   input  logic                i_Sys_clk,
   input  logic                i_Rst,
   poweron_sequencer_if.slave  bus
);
   localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int PRE_W = (SYSCLK_FREQ > 1) ? $clog2(SYSCLK_FREQ) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(CH_NUM - 1);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SYSCLK_FREQ - 1);
   localparam logic             TO_EN = (PG_TIMEOUT_US > 0);
   localparam logic [DLY_W-1:0] TO_M1 =
      (PG_TIMEOUT_US > 0) ? DLY_W'(PG_TIMEOUT_US - 1) : '0;
   localparam logic             DN_ZERO = (DOWN_DELAY_US == 0);
   localparam logic [DLY_W-1:0] DN_M1 =
      (DOWN_DELAY_US > 0) ? DLY_W'(DOWN_DELAY_US - 1) : '0;

   typedef enum logic [2:0] {
      IDLE, UP_WAIT, UP_PG, DONE, DOWN_WAIT, FAULT
   } state_t;

   state_t            state, state_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [CH_NUM-1:0] en, en_n;
   logic [IDX_W-1:0]  fault_ch, fault_ch_n;
   logic [CH_NUM-1:0] pg_m, pg_s;
   logic [PRE_W-1:0]  pre;
   logic [DLY_W-1:0]  us, dly, dly_n;
   logic              tick, clr;
   logic              any_en;
   logic [IDX_W-1:0]  hi_en, lo_drop;
   logic              to_hit, dn_hit;

   assign tick   = (pre == PRE_MAX);
   // Tick-qualified compares fire on the edge where the µs count lands.
   assign to_hit = TO_EN && tick && (us == TO_M1);
   assign dn_hit = DN_ZERO || (tick && (us == DN_M1));
   assign clr    = (state_n != state) || (idx_n != idx);
   assign dly_n  = bus.i_Delay_cfg[int'(idx_n)*DLY_W +: DLY_W];

   always_comb begin
      any_en  = |en;
      hi_en   = '0;
      lo_drop = '0;
      for (int k = 0; k < CH_NUM; k++)
         if (en[k]) hi_en = IDX_W'(k);
      for (int k = CH_NUM - 1; k >= 0; k--)
         if (!pg_s[k]) lo_drop = IDX_W'(k);
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      en_n       = en;
      fault_ch_n = fault_ch;
      unique case (state)
         IDLE: begin
            if (bus.i_Start) begin
               state_n = UP_WAIT;
               idx_n   = '0;
            end
         end
         UP_WAIT, UP_PG: begin
            if (!bus.i_Start) begin
               if (any_en) begin
                  state_n = DOWN_WAIT;
                  idx_n   = hi_en;
               end else begin
                  state_n = IDLE;
               end
            end else if (state == UP_WAIT) begin
               if (us == dly) begin
                  en_n[idx] = 1'b1;
                  state_n   = UP_PG;
               end
            end else if (pg_s[idx]) begin
               if (idx == LAST) begin
                  state_n = DONE;
               end else begin
                  idx_n   = idx + IDX_W'(1);
                  state_n = UP_WAIT;
               end
            end else if (to_hit) begin
               state_n    = FAULT;
               fault_ch_n = idx;
               en_n       = '0;
            end
         end
         DONE: begin
            if (!(&pg_s)) begin
               state_n    = FAULT;
               fault_ch_n = lo_drop;
               en_n       = '0;
            end else if (!bus.i_Start) begin
               state_n = DOWN_WAIT;
               idx_n   = LAST;
            end
         end
         DOWN_WAIT: begin
            if (dn_hit) begin
               en_n[idx] = 1'b0;
               if (idx == '0) state_n = IDLE;
               else           idx_n   = idx - IDX_W'(1);
            end
         end
         FAULT: begin
            en_n = '0;
            if (!bus.i_Start) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
      if (i_Rst) begin
         state    <= IDLE;
         idx      <= '0;
         en       <= '0;
         fault_ch <= '0;
         pg_m     <= '0;
         pg_s     <= '0;
         pre      <= '0;
         us       <= '0;
         dly      <= '0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         en       <= en_n;
         fault_ch <= fault_ch_n;
         pg_m     <= bus.i_Pg;
         pg_s     <= pg_m;
         if (clr) begin
            pre <= '0;
            us  <= '0;
            dly <= dly_n;
         end else begin
            pre <= tick ? '0 : pre + PRE_W'(1);
            if (tick && !(&us)) us <= us + DLY_W'(1);
         end
      end
   end

   assign bus.o_En       = en;
   assign bus.o_All_done = (state == DONE);
   assign bus.o_Busy     = (state == UP_WAIT) || (state == UP_PG) ||
                           (state == DOWN_WAIT);
   assign bus.o_Fault    = (state == FAULT);
   assign bus.o_Fault_ch = fault_ch;
endmodule

// File: tb/tb_poweron_sequencer.sv
// Directed bench for poweron_sequencer: 10 cycles/µs, 4 rails,
// PG timeout 20 µs, down spacing 3 µs, PG echoed ~3 cycles after enable.
module tb_poweron_sequencer;
   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;
   logic [3:0] pg_mask;
   logic [3:0] p0 = '0, p1 = '0, p2 = '0;

   poweron_sequencer_if #(.CH_NUM(4), .DLY_W(20)) sif ();

   poweron_sequencer #(
      .SYSCLK_FREQ(10),
      .CH_NUM(4),
      .DLY_W(20),
      .PG_TIMEOUT_US(20),
      .DOWN_DELAY_US(3)
   ) dut (
      .i_Sys_clk(clk),
      .i_Rst(rst),
      .bus(sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // PG model: each rail reports good ~3 cycles after its enable.
   always @(negedge clk) begin
      p2 <= p1;
      p1 <= p0;
      p0 <= sif.o_En;
   end
   assign sif.i_Pg = p2 & pg_mask;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_en(input int b, input logic v, output int t);
      t = -1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (sif.o_En[b] === v) begin
            t = cyc;
            break;
         end
      end
      if (t < 0)
         chk($sformatf("wait_en%0d", b), 32'(sif.o_En[b]), 32'(v));
   endtask

   int t, t0, te, t2, t3;

   initial begin
      rst = 1'b1;
      sif.i_Start = 1'b0;
      pg_mask = 4'hF;
      sif.i_Delay_cfg = {20'd2, 20'd10, 20'd5, 20'd0};
      repeat (3) @(negedge clk);
      chk("rst_en",    32'(sif.o_En), 32'd0);
      chk("rst_busy",  32'(sif.o_Busy), 32'd0);
      chk("rst_done",  32'(sif.o_All_done), 32'd0);
      chk("rst_fault", 32'(sif.o_Fault), 32'd0);
      chk("rst_fch",   32'(sif.o_Fault_ch), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // power-up
      t0 = cyc;
      sif.i_Start = 1'b1;
      wait_en(0, 1'b1, t);
      chk("up_en0", 32'(t - t0), 32'd2);
      te = t;
      wait_en(1, 1'b1, t);
      chk("up_en1", 32'(t - te), 32'd56);
      te = t;
      wait_en(2, 1'b1, t);
      chk("up_en2", 32'(t - te), 32'd106);
      te = t;
      wait_en(3, 1'b1, t);
      chk("up_en3", 32'(t - te), 32'd26);
      repeat (4) @(negedge clk);
      chk("up_done_pre", 32'(sif.o_All_done), 32'd0);
      chk("up_busy_pre", 32'(sif.o_Busy), 32'd1);
      @(negedge clk);
      chk("up_done", 32'(sif.o_All_done), 32'd1);
      chk("up_busy", 32'(sif.o_Busy), 32'd0);
      chk("up_en_all", 32'(sif.o_En), 32'hF);

      // power-down from DONE
      t0 = cyc;
      sif.i_Start = 1'b0;
      @(negedge clk);
      chk("dn_done", 32'(sif.o_All_done), 32'd0);
      chk("dn_busy", 32'(sif.o_Busy), 32'd1);
      wait_en(3, 1'b0, t);
      chk("dn_en3", 32'(t - t0), 32'd31);
      chk("dn_en3_v", 32'(sif.o_En), 32'h7);
      te = t;
      wait_en(2, 1'b0, t);
      chk("dn_en2", 32'(t - te), 32'd30);
      te = t;
      wait_en(1, 1'b0, t);
      chk("dn_en1", 32'(t - te), 32'd30);
      te = t;
      wait_en(0, 1'b0, t);
      chk("dn_en0", 32'(t - te), 32'd30);
      chk("dn_idle_busy", 32'(sif.o_Busy), 32'd0);

      // PG timeout on rail 2
      repeat (5) @(negedge clk);
      pg_mask = 4'b1011;
      sif.i_Start = 1'b1;
      wait_en(2, 1'b1, t);
      repeat (199) @(negedge clk);
      chk("to_pre_fault", 32'(sif.o_Fault), 32'd0);
      chk("to_pre_en", 32'(sif.o_En), 32'h7);
      @(negedge clk);
      chk("to_en", 32'(sif.o_En), 32'd0);
      chk("to_fault", 32'(sif.o_Fault), 32'd1);
      chk("to_fch", 32'(sif.o_Fault_ch), 32'd2);
      chk("to_busy", 32'(sif.o_Busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("to_sticky", 32'(sif.o_Fault), 32'd1);
      sif.i_Start = 1'b0;
      @(negedge clk);
      chk("to_clear", 32'(sif.o_Fault), 32'd0);
      pg_mask = 4'hF;

      // PG drop on rails 1 and 3 in DONE
      repeat (5) @(negedge clk);
      sif.i_Start = 1'b1;
      wait_en(3, 1'b1, t);
      repeat (5) @(negedge clk);
      chk("pd_done", 32'(sif.o_All_done), 32'd1);
      pg_mask = 4'b0101;
      repeat (2) @(negedge clk);
      chk("pd_pre_fault", 32'(sif.o_Fault), 32'd0);
      @(negedge clk);
      chk("pd_fault", 32'(sif.o_Fault), 32'd1);
      chk("pd_fch", 32'(sif.o_Fault_ch), 32'd1);
      chk("pd_en", 32'(sif.o_En), 32'd0);
      chk("pd_done0", 32'(sif.o_All_done), 32'd0);
      sif.i_Start = 1'b0;
      @(negedge clk);
      pg_mask = 4'hF;
      chk("pd_clear", 32'(sif.o_Fault), 32'd0);

      // abort while waiting for PG on rail 1
      repeat (5) @(negedge clk);
      pg_mask = 4'b1101;
      sif.i_Start = 1'b1;
      wait_en(1, 1'b1, t);
      repeat (2) @(negedge clk);
      chk("ab_en", 32'(sif.o_En), 32'h3);
      chk("ab_busy", 32'(sif.o_Busy), 32'd1);
      te = cyc;
      sif.i_Start = 1'b0;
      wait_en(1, 1'b0, t2);
      chk("ab_en1", 32'(t2 - te), 32'd31);
      chk("ab_en1_v", 32'(sif.o_En), 32'h1);
      wait_en(0, 1'b0, t3);
      chk("ab_en0", 32'(t3 - t2), 32'd30);
      chk("ab_fault", 32'(sif.o_Fault), 32'd0);
      chk("ab_busy0", 32'(sif.o_Busy), 32'd0);
      pg_mask = 4'hF;

      // async reset mid UP_WAIT, then restart
      repeat (5) @(negedge clk);
      sif.i_Start = 1'b1;
      wait_en(0, 1'b1, t);
      repeat (10) @(negedge clk);
      chk("rs_en_pre", 32'(sif.o_En), 32'h1);
      chk("rs_busy_pre", 32'(sif.o_Busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rs_en", 32'(sif.o_En), 32'd0);
      chk("rs_busy", 32'(sif.o_Busy), 32'd0);
      chk("rs_fault", 32'(sif.o_Fault), 32'd0);
      repeat (5) @(negedge clk);
      t0 = cyc;
      rst = 1'b0;
      wait_en(0, 1'b1, t);
      chk("rs_en0", 32'(t - t0), 32'd2);
      chk("rs_en0_v", 32'(sif.o_En), 32'h1);
      wait_en(3, 1'b1, t);
      repeat (5) @(negedge clk);
      chk("rs_done", 32'(sif.o_All_done), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
